mips_pc_sequencer: RTL and testbench
====================================

// Module: mips_pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the MIPS32 SoC core: owns the PC register and its next-PC mux
//  (sequential / branch / j / jal / jr), adds pipeline-stall hold, and replaces the hold-PC-on-error
//  behaviour with a proper exception FSM: latched cause, EPC, halt-or-vector mode, double-fault detection.
//  Sits between control unit / branch resolver / address decoders and the instruction-memory PC decoder.
// PARAMETERS
//  ADDR_W        32            PC width; must be >= 28 (jump target uses pc_plus4[ADDR_W-1:28])
//  RESET_VECTOR  32'h0040_0000 PC value loaded by reset
//  EXC_VECTOR    32'h0040_0180 PC loaded on exception when HALT_ON_EXC=0
//  N_EXC         3             external exception sources (0=invalid opcode, 1=invalid addr, 2=invalid PC)
//  HALT_ON_EXC   1             1: exception -> HALT; 0: exception -> vector to EXC_VECTOR, keep running
// PORTS
//  clk           in   1                 clock, all state on rising edge
//  reset         in   1                 asynchronous, active-low reset
//  stall         in   1                 hold PC this cycle (no update)
//  branch_taken  in   1                 from branch resolver
//  imm32         in   ADDR_W            sign-extended branch offset (words)
//  jump          in   1                 j or jal
//  inst_index    in   26                instruction bits [25:0]
//  jr            in   1                 jr/jalr
//  jr_target     in   ADDR_W            rs register value
//  exc_req       in   N_EXC             exception requests, level, sampled each RUN cycle
//  exc_ack       in   1                 clears exc_pending
//  resume        in   1                 leave HALT
//  pc            out  ADDR_W            current PC
//  pc_plus4      out  ADDR_W            pc + 4 (comb.), for jal link
//  pc_valid      out  1                 1 in RUN only; gates register-file/memory writes
//  halted        out  1                 1 in HALT
//  exc_valid     out  1                 one-cycle pulse when an exception is taken
//  exc_pending   out  1                 sticky, set on exception, cleared by exc_ack
//  exc_cause     out  CW                CW = $clog2(N_EXC+1); latched cause code
//  epc           out  ADDR_W            PC of faulting instruction
// BEHAVIOUR
//  Reset (reset=0, async): pc=RESET_VECTOR, state=BOOT, pc_valid=0, halted=0, exc_valid=0, exc_pending=0,
//   exc_cause=0, epc=0. BOOT lasts exactly one clock after release, PC unchanged, then RUN.
//  Arithmetic mod 2^ADDR_W: pc_plus4=pc+4; branch tgt=pc_plus4+(imm32<<2); jump tgt=
//   {pc_plus4[ADDR_W-1:28],inst_index,2'b00}. All wrap silently, no overflow flag.
//  Misaligned jr (jr=1, jr_target[1:0]!=0) is an internal exception, cause code N_EXC.
//  RUN priority per cycle: exception > stall > jr > jump > branch_taken > pc_plus4.
//   Exceptions override stall. Cause = lowest set exc_req index; misaligned jr only if exc_req==0.
//  Exception taken: epc<=pc, exc_cause<=code, exc_pending<=1, exc_valid=1 next cycle for one cycle;
//   HALT_ON_EXC=1 -> state HALT, pc held; HALT_ON_EXC=0 -> pc<=EXC_VECTOR, stay RUN.
//  Double fault: exception while exc_pending=1 -> HALT regardless of HALT_ON_EXC; epc/cause overwritten.
//  exc_ack same cycle as new exception: new exception wins, exc_pending stays 1, not a double fault.
//  HALT: pc, epc, cause frozen; pc_valid=0; exc_req/stall/jumps ignored. resume=1 -> pc<=epc+4,
//   exc_pending<=0, state RUN next cycle. resume outside HALT ignored.
//  States: BOOT->RUN (always); RUN->HALT (exc & (HALT_ON_EXC|exc_pending)); HALT->RUN (resume).
//  Reset mid-anything (incl. HALT) returns to reset values immediately, no clock required.
// TESTING
//  1 Release reset, no controls -> pc 0x400000 for BOOT+1st RUN cycle, then 0x400004, 0x400008; pc_valid 0 then 1.
//  2 pc=0x400010, branch_taken, imm32=-4 -> pc 0x400004; jump+branch same cycle, inst_index=0x10 -> 0x40.
//  3 stall=1 3 cycles with jr=1 -> pc frozen; stall+exc_req[1] -> exception taken, epc=stalled pc, cause=1.
//  4 HALT_ON_EXC=1, exc_req=3'b110 at pc 0x400020 -> cause 1, halted=1, pc held; resume -> pc 0x400024.
//  5 HALT_ON_EXC=0, exc_req[0] -> pc 0x400180, exc_valid 1 cycle; 2nd exc before exc_ack -> halted=1.
//  6 jr_target=0x400002 -> cause 3, epc=jr pc; reset asserted while HALT -> pc 0x400000 same cycle.

Source files
------------

// File: rtl/mips_pc_sequencer.sv
// Program-counter sequencer: PC register, next-PC selection (sequential/branch/j/jr),
// stall hold and a BOOT/RUN/HALT exception FSM with latched cause, EPC and double-fault detection.
module mips_pc_sequencer #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 'h0040_0000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 'h0040_0180,
  parameter int unsigned       N_EXC        = 3,
  parameter bit                HALT_ON_EXC  = 1'b1,
  localparam int unsigned      CW           = $clog2(N_EXC + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_stall,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_imm32,
  input  logic              i_jump,
  input  logic [25:0]       i_inst_index,
  input  logic              i_jr,
  input  logic [ADDR_W-1:0] i_jr_target,
  input  logic [N_EXC-1:0]  i_exc_req,
  input  logic              i_exc_ack,
  input  logic              i_resume,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic              o_pc_valid,
  output logic              o_halted,
  output logic              o_exc_valid,
  output logic              o_exc_pending,
  output logic [CW-1:0]     o_exc_cause,
  output logic [ADDR_W-1:0] o_epc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(28'hFFF_FFFF);
  localparam logic [ADDR_W-1:0] FOUR      = ADDR_W'(4);
  localparam logic [CW-1:0]     MISALIGN  = CW'(N_EXC);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_epc;
  logic [CW-1:0]     r_excCause;
  logic              r_excPending;
  logic              r_excValid;

  logic [ADDR_W-1:0] w_pcPlus4;
  logic [ADDR_W-1:0] w_branchTgt;
  logic [ADDR_W-1:0] w_jumpTgt;
  logic [ADDR_W-1:0] w_nextPc;
  logic [CW-1:0]     w_hwCause;
  logic [CW-1:0]     w_excCode;
  logic              w_hwExc;
  logic              w_misalignJr;
  logic              w_take;
  logic              w_doubleFault;
  logic              w_toHalt;
  logic              w_resumeNow;

  assign w_pcPlus4   = r_pc + FOUR;
  assign w_branchTgt = w_pcPlus4 + (i_imm32 << 2);
  assign w_jumpTgt   = (w_pcPlus4 & ~LOW_MASK) | ADDR_W'({i_inst_index, 2'b00});

  // Lowest-numbered external request wins; misaligned jr only counts when no external request.
  always_comb begin
    w_hwCause = '0;
    for (int i = N_EXC - 1; i >= 0; i--) begin
      if (i_exc_req[i]) w_hwCause = CW'(i);
    end
  end

  assign w_hwExc       = |i_exc_req;
  assign w_misalignJr  = i_jr & (i_jr_target[1:0] != 2'b00);
  assign w_excCode     = w_hwExc ? w_hwCause : MISALIGN;
  assign w_take        = (r_state == RUN) & (w_hwExc | w_misalignJr);
  assign w_doubleFault = w_take & r_excPending & ~i_exc_ack;
  assign w_toHalt      = w_take & (HALT_ON_EXC | w_doubleFault);
  assign w_resumeNow   = (r_state == HALT) & i_resume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    case (r_state)
      BOOT: w_nextState = RUN;
      RUN: begin
        if (w_take) begin
          if (w_toHalt) w_nextState = HALT;
          else          w_nextPc    = EXC_VECTOR;
        end else if (i_stall) begin
          w_nextPc = r_pc;
        end else if (i_jr) begin
          w_nextPc = i_jr_target;
        end else if (i_jump) begin
          w_nextPc = w_jumpTgt;
        end else if (i_branch_taken) begin
          w_nextPc = w_branchTgt;
        end else begin
          w_nextPc = w_pcPlus4;
        end
      end
      HALT: begin
        if (i_resume) begin
          w_nextState = RUN;
          w_nextPc    = r_epc + FOUR;
        end
      end
      default: w_nextState = BOOT;
    endcase
  end

  // A new exception outranks a same-cycle acknowledge, so pending stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_excCause   <= '0;
      r_excPending <= 1'b0;
      r_excValid   <= 1'b0;
    end else begin
      r_pc       <= w_nextPc;
      r_excValid <= w_take;
      if (w_take) begin
        r_epc        <= r_pc;
        r_excCause   <= w_excCode;
        r_excPending <= 1'b1;
      end else if (w_resumeNow || i_exc_ack) begin
        r_excPending <= 1'b0;
      end
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pcPlus4;
  assign o_pc_valid    = (r_state == RUN);
  assign o_halted      = (r_state == HALT);
  assign o_exc_valid   = r_excValid;
  assign o_exc_pending = r_excPending;
  assign o_exc_cause   = r_excCause;
  assign o_epc         = r_epc;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed bench for mips_pc_sequencer: halt-mode instance for sequencing/halt tests,
// vector-mode instance for vectoring, double-fault and acknowledge tests.
module tb_mips_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branchTaken, jump, jr, excAck, resume;
  logic [31:0] imm32, jrTarget;
  logic [25:0] instIndex;
  logic [2:0]  excReq;

  logic [31:0] hPc, hPcPlus4, hEpc, vPc, vPcPlus4, vEpc;
  logic        hValid, hHalted, hExcValid, hPending;
  logic        vValid, vHalted, vExcValid, vPending;
  logic [1:0]  hCause, vCause;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clk = ~clk;

  mips_pc_sequencer #(.HALT_ON_EXC(1'b1)) dutHalt (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_branch_taken(branchTaken),
    .i_imm32(imm32), .i_jump(jump), .i_inst_index(instIndex), .i_jr(jr),
    .i_jr_target(jrTarget), .i_exc_req(excReq), .i_exc_ack(excAck), .i_resume(resume),
    .o_pc(hPc), .o_pc_plus4(hPcPlus4), .o_pc_valid(hValid), .o_halted(hHalted),
    .o_exc_valid(hExcValid), .o_exc_pending(hPending), .o_exc_cause(hCause), .o_epc(hEpc)
  );

  mips_pc_sequencer #(.HALT_ON_EXC(1'b0)) dutVec (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_branch_taken(branchTaken),
    .i_imm32(imm32), .i_jump(jump), .i_inst_index(instIndex), .i_jr(jr),
    .i_jr_target(jrTarget), .i_exc_req(excReq), .i_exc_ack(excAck), .i_resume(resume),
    .o_pc(vPc), .o_pc_plus4(vPcPlus4), .o_pc_valid(vValid), .o_halted(vHalted),
    .o_exc_valid(vExcValid), .o_exc_pending(vPending), .o_exc_cause(vCause), .o_epc(vEpc)
  );

  // Outputs are sampled 1 ns after the rising edge, inputs changed at the same point.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearControls();
    stall = 0; branchTaken = 0; jump = 0; jr = 0; excAck = 0; resume = 0;
    imm32 = '0; jrTarget = '0; instIndex = '0; excReq = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clearControls();
    #12;
    checkOutput("reset pc", hPc, 32'h0040_0000);
    checkOutput("reset pc_valid", hValid, 0);
    checkOutput("reset halted", hHalted, 0);
    checkOutput("reset exc_valid", hExcValid, 0);
    checkOutput("reset pending", hPending, 0);
    checkOutput("reset cause", hCause, 0);
    checkOutput("reset epc", hEpc, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("boot pc_valid", hValid, 0);

    // Sequential fetch after BOOT
    applyStimulus();
    checkOutput("run1 pc", hPc, 32'h0040_0000);
    checkOutput("run1 pc_valid", hValid, 1);
    applyStimulus();
    checkOutput("seq pc 4", hPc, 32'h0040_0004);
    applyStimulus();
    checkOutput("seq pc 8", hPc, 32'h0040_0008);

    jr = 1; jrTarget = 32'h0040_0010;
    applyStimulus();
    checkOutput("jr pc", hPc, 32'h0040_0010);

    jr = 0; branchTaken = 1; imm32 = 32'hFFFF_FFFC;
    applyStimulus();
    checkOutput("branch back pc", hPc, 32'h0040_0004);

    jump = 1; instIndex = 26'h10;
    applyStimulus();
    checkOutput("jump over branch pc", hPc, 32'h0000_0040);
    checkOutput("pc_plus4", hPcPlus4, 32'h0000_0044);

    // Stall beats jr; exception beats stall
    clearControls();
    stall = 1; jr = 1; jrTarget = 32'h0040_0020;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("stall hold pc", hPc, 32'h0000_0040);
    end
    jr = 0; excReq = 3'b010;
    applyStimulus();
    checkOutput("stall exc halted", hHalted, 1);
    checkOutput("stall exc pc", hPc, 32'h0000_0040);
    checkOutput("stall exc epc", hEpc, 32'h0000_0040);
    checkOutput("stall exc cause", hCause, 1);
    checkOutput("stall exc exc_valid", hExcValid, 1);
    checkOutput("stall exc pending", hPending, 1);
    checkOutput("halt pc_valid", hValid, 0);

    clearControls();
    jump = 1; excReq = 3'b001; instIndex = 26'h3;
    applyStimulus();
    checkOutput("halt frozen pc", hPc, 32'h0000_0040);
    checkOutput("halt frozen cause", hCause, 1);
    checkOutput("exc_valid one cycle", hExcValid, 0);
    checkOutput("still halted", hHalted, 1);

    clearControls();
    resume = 1;
    applyStimulus();
    checkOutput("resume pc", hPc, 32'h0000_0044);
    checkOutput("resume halted", hHalted, 0);
    checkOutput("resume pending", hPending, 0);

    resume = 0; jr = 1; jrTarget = 32'h0040_0020;
    applyStimulus();
    checkOutput("jr to 0x400020", hPc, 32'h0040_0020);

    jr = 0; excReq = 3'b110;
    applyStimulus();
    checkOutput("multi exc cause", hCause, 1);
    checkOutput("multi exc halted", hHalted, 1);
    checkOutput("multi exc pc", hPc, 32'h0040_0020);
    checkOutput("multi exc epc", hEpc, 32'h0040_0020);

    excReq = 0; resume = 1;
    applyStimulus();
    checkOutput("resume epc+4", hPc, 32'h0040_0024);
    applyStimulus();
    checkOutput("resume ignored in run", hPc, 32'h0040_0028);

    resume = 0; jr = 1; jrTarget = 32'h0040_0002;
    applyStimulus();
    checkOutput("misalign cause", hCause, 3);
    checkOutput("misalign epc", hEpc, 32'h0040_0028);
    checkOutput("misalign halted", hHalted, 1);
    checkOutput("misalign pc", hPc, 32'h0040_0028);

    clearControls();
    rst_n = 1'b0;
    #1;
    checkOutput("async reset pc", hPc, 32'h0040_0000);
    checkOutput("async reset halted", hHalted, 0);
    checkOutput("async reset pending", hPending, 0);
    checkOutput("async reset cause", hCause, 0);
    #2;
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("vec run pc", vPc, 32'h0040_0000);

    // Vector mode: exceptions jump to EXC_VECTOR and keep running
    excReq = 3'b001;
    applyStimulus();
    checkOutput("vec pc", vPc, 32'h0040_0180);
    checkOutput("vec exc_valid", vExcValid, 1);
    checkOutput("vec cause", vCause, 0);
    checkOutput("vec epc", vEpc, 32'h0040_0000);
    checkOutput("vec pending", vPending, 1);
    checkOutput("vec halted", vHalted, 0);

    excReq = 0;
    applyStimulus();
    checkOutput("vec handler pc", vPc, 32'h0040_0184);
    checkOutput("vec exc_valid drop", vExcValid, 0);
    checkOutput("vec pending sticky", vPending, 1);

    excReq = 3'b100;
    applyStimulus();
    checkOutput("double fault halted", vHalted, 1);
    checkOutput("double fault cause", vCause, 2);
    checkOutput("double fault epc", vEpc, 32'h0040_0184);
    checkOutput("double fault pc", vPc, 32'h0040_0184);

    excReq = 0; resume = 1;
    applyStimulus();
    checkOutput("vec resume pc", vPc, 32'h0040_0188);
    checkOutput("vec resume pending", vPending, 0);

    resume = 0; excReq = 3'b001;
    applyStimulus();
    checkOutput("vec exc2 pc", vPc, 32'h0040_0180);
    checkOutput("vec exc2 epc", vEpc, 32'h0040_0188);

    excAck = 1;
    applyStimulus();
    checkOutput("ack+exc not halted", vHalted, 0);
    checkOutput("ack+exc pc", vPc, 32'h0040_0180);
    checkOutput("ack+exc epc", vEpc, 32'h0040_0180);
    checkOutput("ack+exc pending", vPending, 1);

    excReq = 0;
    applyStimulus();
    checkOutput("ack clears pending", vPending, 0);
    checkOutput("ack cycle pc", vPc, 32'h0040_0184);

    excAck = 0; jr = 1; jrTarget = 32'hFFFF_FFFC;
    applyStimulus();
    checkOutput("jr top pc", vPc, 32'hFFFF_FFFC);
    checkOutput("wrap pc_plus4", vPcPlus4, 32'h0000_0000);
    jr = 0;
    applyStimulus();
    checkOutput("wrap pc", vPc, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
